// File: rtl/morse_keyer.sv
// morse_keyer
//   Turns one Morse character (or a word-space token) per valid/ready
//   handshake into an on/off key waveform. All durations are counted in
//   pulses of the one-unit clock enable 'tick' from the upstream prescaler.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   tick       one-unit clock enable (single-cycle pulse, may be held high)
//   in_valid   character/token offered by the source
//   in_ready   block can accept (IDLE and out of reset)
//   in_pattern element bits, LSB first; 0 = dot, 1 = dash
//   in_len     number of elements, 0..MAX_LEN (larger values clamp)
//   in_word    word-space token; pattern and length ignored when set
//   key        Morse key, 1 = mark
//   busy       high whenever not IDLE
//   done       one-clk pulse when a character or token finishes
module morse_keyer #(
  parameter int MAX_LEN    = 6,
  parameter int LEN_W      = $clog2(MAX_LEN + 1),
  parameter int DOT_U      = 1,
  parameter int DASH_U     = 3,
  parameter int ELEM_GAP_U = 1,
  parameter int CHAR_GAP_U = 3,
  parameter int WORD_GAP_U = 7,
  parameter int CNT_W      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAX_LEN-1:0] in_pattern,
  input  logic [LEN_W-1:0]   in_len,
  input  logic               in_word,
  output logic               key,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, WAIT, MARK, SPACE} state_t;

  // Counter reload values: a span of N units is N tick edges, so the
  // counter is loaded with N-1 and the span ends on the tick that sees 0.
  localparam logic [CNT_W-1:0] DOT_LD  = CNT_W'(DOT_U - 1);
  localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(DASH_U - 1);
  localparam logic [CNT_W-1:0] ELEM_LD = CNT_W'(ELEM_GAP_U - 1);
  localparam logic [CNT_W-1:0] CHAR_LD = CNT_W'(CHAR_GAP_U - 1);
  localparam logic [CNT_W-1:0] WORD_LD = CNT_W'(WORD_GAP_U - CHAR_GAP_U - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t             state;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   remaining;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic               is_word;
  logic               ready_en;
  logic [LEN_W-1:0]   len_clamped;

  assign len_clamped = (in_len > LEN_MAX) ? LEN_MAX : in_len;

  // ready_en keeps in_ready low while reset is held and rises on the first
  // clock after release, independent of the state register.
  assign in_ready = ready_en && (state == IDLE);
  assign busy     = (state != IDLE);

  // Single sequencer: the handshake is the only transition not gated by
  // tick, so a tick coincident with the accept edge is never counted.
  // The pattern is shifted right as elements are consumed so bit 0 always
  // holds the next element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pattern   <= '0;
      remaining <= '0;
      cnt       <= '0;
      last      <= 1'b0;
      is_word   <= 1'b0;
      ready_en  <= 1'b0;
      key       <= 1'b0;
      done      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (in_word) begin
              is_word <= 1'b1;
              state   <= WAIT;
            end else if (in_len != '0) begin
              is_word   <= 1'b0;
              pattern   <= in_pattern;
              remaining <= len_clamped;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          if (tick) begin
            if (is_word) begin
              cnt   <= WORD_LD;
              last  <= 1'b1;
              state <= SPACE;
            end else begin
              key       <= 1'b1;
              cnt       <= pattern[0] ? DASH_LD : DOT_LD;
              pattern   <= pattern >> 1;
              remaining <= remaining - 1'b1;
              state     <= MARK;
            end
          end
        end
        MARK: begin
          if (tick) begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              key <= 1'b0;
              if (remaining != '0) begin
                cnt  <= ELEM_LD;
                last <= 1'b0;
              end else begin
                cnt  <= CHAR_LD;
                last <= 1'b1;
              end
              state <= SPACE;
            end
          end
        end
        SPACE: begin
          if (tick) begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (!last) begin
              key       <= 1'b1;
              cnt       <= pattern[0] ? DASH_LD : DOT_LD;
              pattern   <= pattern >> 1;
              remaining <= remaining - 1'b1;
              state     <= MARK;
            end else begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
